// File: rtl/ofifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// ofifo_drain_ctrl
//
// Purpose
//   Drains one tile of rows from the compressed output FIFO (ofifo) into the
//   psum SRAM write port. Read pulses are issued toward the ofifo. The row
//   returned one cycle later is parked in a 2-entry in-order holding buffer.
//   The head of that buffer is presented as a valid/ready write, using an
//   address that increments from the tile base. busy/done report progress to
//   the core controller. err_ovf is a sticky flag that records an ofifo-full
//   condition seen while the sequencer was idle.
//
// Ports
//   clk          in   1            clock, all logic on posedge
//   reset        in   1            synchronous, active-high
//   start        in   1            begin draining one tile (honoured in IDLE)
//   base_addr    in   addr_bw      first SRAM address of the tile
//   num_rows     in   len_bw       rows in the tile, 0 = empty tile
//   ofifo_valid  in   1            ofifo has at least one readable row
//   ofifo_full   in   1            ofifo full flag
//   ofifo_rd     out  1            read strobe, one row per asserted cycle
//   ofifo_out    in   col*psum_bw  ofifo data, valid the cycle after ofifo_rd
//   mem_ready    in   1            SRAM accepts a write this cycle
//   mem_wen      out  1            write request valid
//   mem_addr     out  addr_bw      write address (base + accepted, wraps)
//   mem_data     out  col*psum_bw  write data (holding buffer head)
//   busy         out  1            high in every state except IDLE
//   done         out  1            one-cycle pulse once every row is written
//   err_ovf      out  1            sticky ofifo-full-while-idle flag
// ---------------------------------------------------------------------------
module ofifo_drain_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int len_bw  = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [len_bw-1:0]      num_rows,
  input  logic                   ofifo_valid,
  input  logic                   ofifo_full,
  output logic                   ofifo_rd,
  input  logic [col*psum_bw-1:0] ofifo_out,
  input  logic                   mem_ready,
  output logic                   mem_wen,
  output logic [addr_bw-1:0]     mem_addr,
  output logic [col*psum_bw-1:0] mem_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err_ovf
);

  localparam int row_bw = col * psum_bw;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [addr_bw-1:0]  base_reg, base_next;
  logic [len_bw-1:0]   rows_reg, rows_next;
  logic [len_bw-1:0]   issued_reg, issued_next;
  logic [len_bw-1:0]   accepted_reg, accepted_next;
  logic                inflight_reg, inflight_next;
  logic [1:0]          buf_cnt_reg, buf_cnt_next;
  logic                wr_ptr_reg, rd_ptr_reg;
  logic                err_ovf_reg, err_ovf_next;

  logic                push;
  logic                accept;
  logic                rd_ok;
  logic [2:0]          occupancy;
  logic [row_bw-1:0]   head_data;

  // -------------------------------------------------------------------------
  // Handshake and read-issue logic
  // -------------------------------------------------------------------------
  // A read issued last cycle returns its row now; capture it this cycle.
  assign push    = inflight_reg;
  assign mem_wen = (buf_cnt_reg != 2'd0);
  assign accept  = mem_wen & mem_ready;

  // Slots committed after this edge: buffered rows plus the row in flight,
  // minus the head leaving this cycle. Counting the departing head lets the
  // pipe keep one read per cycle when the SRAM is accepting every cycle.
  // accept implies buf_cnt_reg >= 1, so the subtraction cannot underflow.
  assign occupancy = {1'b0, buf_cnt_reg} + {2'b00, inflight_reg} - {2'b00, accept};

  // Reads are also suppressed while reset is asserted. This keeps rows from
  // being pulled out of the ofifo and then dropped by the reset.
  assign rd_ok = (state_reg == DRAIN) & ofifo_valid & (issued_reg < rows_reg) &
                 (occupancy < 3'd2) & ~reset;

  assign ofifo_rd = rd_ok;
  assign mem_addr = base_reg + addr_bw'(accepted_reg);
  assign mem_data = head_data;
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign err_ovf  = err_ovf_reg;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    rows_next     = rows_reg;
    issued_next   = issued_reg + len_bw'(rd_ok);
    accepted_next = accepted_reg + len_bw'(accept);
    inflight_next = rd_ok;
    buf_cnt_next  = buf_cnt_reg + {1'b0, push} - {1'b0, accept};
    err_ovf_next  = err_ovf_reg;

    case (state_reg)
      IDLE: begin
        if (ofifo_full) begin
          err_ovf_next = 1'b1;
        end
        // An accepted start clears the flag, even if full is seen in the
        // same cycle.
        if (start) begin
          base_next     = base_addr;
          rows_next     = num_rows;
          issued_next   = '0;
          accepted_next = '0;
          err_ovf_next  = 1'b0;
          state_next    = (num_rows == '0) ? DONE : DRAIN;
        end
      end

      DRAIN: begin
        // Move on as soon as the last read is issued. The remaining rows
        // are then finished in FLUSH.
        if (rd_ok && ((issued_reg + len_bw'(1)) == rows_reg)) begin
          state_next = FLUSH;
        end else if (issued_reg >= rows_reg) begin
          state_next = FLUSH;
        end
      end

      FLUSH: begin
        // Look one cycle ahead. If the last buffered row is accepted now,
        // done lands in the very next cycle.
        if (!inflight_reg &&
            ((buf_cnt_reg == 2'd0) || ((buf_cnt_reg == 2'd1) && accept))) begin
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      rows_reg     <= '0;
      issued_reg   <= '0;
      accepted_reg <= '0;
      inflight_reg <= 1'b0;
      buf_cnt_reg  <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      err_ovf_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      rows_reg     <= rows_next;
      issued_reg   <= issued_next;
      accepted_reg <= accepted_next;
      inflight_reg <= inflight_next;
      buf_cnt_reg  <= buf_cnt_next;
      // Separate write and read pointers keep the rows in order when a
      // push and a pop happen in the same cycle.
      wr_ptr_reg   <= wr_ptr_reg ^ push;
      rd_ptr_reg   <= rd_ptr_reg ^ accept;
      err_ovf_reg  <= err_ovf_next;
    end
  end

  // -------------------------------------------------------------------------
  // 2-entry holding buffer
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      logic [row_bw-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= ofifo_out;
        end
      end
    end
  endgenerate

  assign head_data = rd_ptr_reg ? g_buf[1].entry_reg : g_buf[0].entry_reg;

endmodule
